// File: rtl/shake_pkg.sv
// Shared constants, FSM encoding and lane-select helper for the SHAKE256 sponge controller.
package shake_pkg;

  localparam int RATE_BITS   = 1088;
  localparam int STATE_BITS  = 1600;
  localparam int LANE_W      = 64;
  localparam int RATE_LANES  = 17;
  localparam int STATE_LANES = STATE_BITS / LANE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PERM_REQ,
    S_PERM_WAIT,
    S_SQUEEZE
  } sponge_state_e;

  // Lane idx of the state; indices past the last lane read as zero.
  function automatic logic [LANE_W-1:0] lane(input logic [STATE_BITS-1:0] s,
                                             input logic [4:0]            idx);
    logic [LANE_W-1:0] w;
    // NOTE: default assignment before the loop keeps the combinational path latch-free.
    w = '0;
    for (int i = 0; i < STATE_LANES; i++) begin
      if (idx == 5'(i)) w = s[i*LANE_W +: LANE_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/shake_lane_mux.sv
// Combinational selector of one 64-bit lane out of the 1600-bit Keccak state.
module shake_lane_mux
  import shake_pkg::*;
(
  input  logic [STATE_BITS-1:0] i_state,
  input  logic [4:0]            i_idx,
  output logic [LANE_W-1:0]     o_lane
);

  assign o_lane = lane(i_state, i_idx);

endmodule

// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 sponge controller: absorbs padded rate blocks, sequences an external
// Keccak-f[1600] core and squeezes the requested number of 64-bit words.
module shake256_sponge_ctrl #(
  parameter int RATE_BITS  = shake_pkg::RATE_BITS,
  parameter int STATE_BITS = shake_pkg::STATE_BITS,
  parameter int LANE_W     = shake_pkg::LANE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RATE_BITS-1:0]  block_in,
  input  logic                  block_valid,
  input  logic                  block_last,
  output logic                  block_ready,
  input  logic [7:0]            out_words,
  output logic                  perm_start,
  output logic [STATE_BITS-1:0] perm_state_out,
  input  logic [STATE_BITS-1:0] perm_state_in,
  input  logic                  perm_done,
  output logic [LANE_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  error_flag
);

  import shake_pkg::*;

  sponge_state_e         r_fsm;
  logic [STATE_BITS-1:0] r_sponge;
  logic [4:0]            r_lane_idx;
  logic [7:0]            r_emitted;
  logic [7:0]            r_out_words;
  logic                  r_last;
  logic                  r_block_ready;
  logic                  r_busy;
  logic                  r_perm_start;
  logic                  r_dout_valid;
  logic                  r_error;

  logic                  w_final_word;
  logic [LANE_W-1:0]     w_lane;

  shake_lane_mux u_lane_mux (
    .i_state (r_sponge),
    .i_idx   (r_lane_idx),
    .o_lane  (w_lane)
  );

  assign w_final_word = (r_emitted == r_out_words - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm         <= S_IDLE;
      r_sponge      <= '0;
      r_lane_idx    <= '0;
      r_emitted     <= '0;
      r_out_words   <= '0;
      r_last        <= 1'b0;
      r_block_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_perm_start  <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch decides on pre-edge values.
      r_perm_start <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          // block_ready is registered, so the first post-reset cycle cannot accept.
          if (r_block_ready && block_valid) begin
            r_sponge[RATE_BITS-1:0] <= r_sponge[RATE_BITS-1:0] ^ block_in;
            r_last                  <= block_last;
            if (block_last) r_out_words <= out_words;
            r_fsm         <= S_PERM_REQ;
            r_perm_start  <= 1'b1;
            r_block_ready <= 1'b0;
            r_busy        <= 1'b1;
          end else begin
            r_block_ready <= 1'b1;
          end
        end
        S_PERM_REQ: r_fsm <= S_PERM_WAIT;
        S_PERM_WAIT: begin
          if (perm_done) begin
            if (!r_last) begin
              r_sponge      <= perm_state_in;
              r_fsm         <= S_IDLE;
              r_block_ready <= 1'b1;
              r_busy        <= 1'b0;
            end else if (r_out_words == 8'd0) begin
              r_sponge      <= '0;
              r_error       <= 1'b1;
              r_fsm         <= S_IDLE;
              r_block_ready <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_sponge     <= perm_state_in;
              r_lane_idx   <= '0;
              r_fsm        <= S_SQUEEZE;
              r_dout_valid <= 1'b1;
            end
          end
        end
        S_SQUEEZE: begin
          if (dout_ready) begin
            if (w_final_word) begin
              r_sponge      <= '0;
              r_emitted     <= '0;
              r_lane_idx    <= '0;
              r_fsm         <= S_IDLE;
              r_dout_valid  <= 1'b0;
              r_block_ready <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_emitted <= r_emitted + 8'd1;
              if (r_lane_idx == 5'(RATE_LANES - 1)) begin
                // Rate exhausted: permute again before the next word.
                r_lane_idx   <= '0;
                r_fsm        <= S_PERM_REQ;
                r_perm_start <= 1'b1;
                r_dout_valid <= 1'b0;
              end else begin
                r_lane_idx <= r_lane_idx + 5'd1;
              end
            end
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign block_ready    = r_block_ready;
  assign busy           = r_busy;
  assign perm_start     = r_perm_start;
  assign perm_state_out = r_sponge;
  assign dout_valid     = r_dout_valid;
  assign dout           = w_lane;
  assign dout_last      = r_dout_valid && w_final_word;
  assign error_flag     = r_error;

endmodule

// File: doc/shake256_sponge_ctrl.md
# shake256_sponge_ctrl

- Sponge controller sitting directly downstream of `pad136`.
- Accepts 1088-bit padded rate blocks and XORs each into a 1600-bit Keccak state.
- Runs the external Keccak-f[1600] core through a start/done handshake, then squeezes a requested number of 64-bit output words over a valid/ready stream.
- Issues extra permutations whenever the 17-lane rate is exhausted during squeezing.

## Interface
Parameters:
- `RATE_BITS`, 1088, rate in bits (17 lanes)
- `STATE_BITS`, 1600, Keccak state width
- `LANE_W`, 64, output word / lane width

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `block_in`  in  1088  padded rate block; bit j is message bit j (pad136 ordering)
- `block_valid`  in  1  block_in valid (level; driven from pad `valid_output`)
- `block_last`  in  1  block is the final absorb block
- `block_ready`  out  1  high only in IDLE
- `out_words`  in  8  number of 64-bit words to squeeze; sampled on accept of a last block
- `perm_start`  out  1  one-cycle request to permutation core
- `perm_state_out`  out  1600  state presented to core; stable from start until done
- `perm_state_in`  in  1600  permuted state from core
- `perm_done`  in  1  one-cycle completion pulse from core
- `dout`  out  64  squeeze word = state[64k+63:64k], k = lane index
- `dout_valid`  out  1  dout valid
- `dout_ready`  in  1  consumer accepts dout
- `dout_last`  out  1  final requested word
- `busy`  out  1  high in any state other than IDLE
- `error_flag`  out  1  sticky; set when out_words==0 is latched

## Operation
States: IDLE, PERM_REQ, PERM_WAIT, SQUEEZE.
- IDLE: `block_ready`=1.
  - On `block_valid`: state[1087:0] ^= block_in, state[1599:1088] unchanged.
  - Latch `block_last`; if last, latch `out_words`.
  - Go to PERM_REQ.
- PERM_REQ: `perm_start`=1 for exactly one cycle, then PERM_WAIT.
- PERM_WAIT: on `perm_done`, state <= `perm_state_in`. Next state:
  - last not latched: IDLE.
  - last latched, out_words==0: set `error_flag`, clear state, IDLE.
  - otherwise: SQUEEZE with lane index k=0.
- SQUEEZE: `dout_valid`=1. On `dout_valid && dout_ready`: k++ and emitted++.
  - emitted reaches out_words: clear state to zero, clear emitted, IDLE.
  - else if k was 16: k=0, go to PERM_REQ (squeeze permutation).
- `dout_last` = (emitted == out_words-1) while in SQUEEZE.
- `perm_done` outside PERM_WAIT is ignored.
- `block_valid` outside IDLE is ignored.
- `perm_state_out` = state register at all times.

## Timing
- Reset values: all outputs 0; state register 0; FSM in IDLE. `block_ready` becomes 1 in the first cycle after `reset_n` deasserts.
- Accept in cycle T → `perm_start` in T+1 → PERM_WAIT from T+2.
- `perm_done` in cycle D → state updated at D+1; `dout_valid` or `block_ready` high in D+1.
- `dout` and `dout_last` are combinational from registered state and k. They are held stable while `dout_valid && !dout_ready`.
- Squeeze throughput: 1 word/cycle with `dout_ready` held high. Between word 17n+16 and word 17(n+1) there are 2 + core latency cycles.
- Reset asserted mid-operation (any state): immediate return to reset values. An in-flight core result is discarded.
- Counters: k is 5 bits (0..16). emitted is 8 bits and never wraps, since out_words ≤ 255.

## Structure
- Shared package `shake_pkg`:
  - `RATE_BITS`, `STATE_BITS`, `LANE_W`, `RATE_LANES`=17.
  - The sponge state enum.
  - A `lane(idx)` helper function.
- One natural sub-module: `shake_lane_mux`, selecting 64-bit lane k from the 1600-bit state (combinational).
- Keccak-f[1600] is the existing separate core, instantiated by the parent, not here.

## Test plan
- Reset check: hold `reset_n`=0 → all outputs 0. Release → `block_ready`=1 next cycle, `busy`=0.
- Empty-message SHAKE256:
  - Stimulus: block with byte0=0x1F, byte135=0x80, last=1, out_words=4, behavioural Keccak model, `dout_ready`=1.
  - Required: first `dout`=0x138da80b2bddb946; 4 words; `dout_last` on the 4th; then IDLE with state zero.
- Long squeeze: out_words=20 → exactly two `perm_start` pulses after absorb (one absorb, one squeeze). Words 0–16 come from the first state, 17–19 from the second.
- Multi-block absorb:
  - Stimulus: two blocks, last=0 then last=1.
  - Required: `block_ready` returns between them; second XOR applies to the permuted state; output matches the model.
- Backpressure: toggle `dout_ready` randomly → no word dropped or duplicated, and `dout` is stable while stalled.
- Error and reset:
  - out_words=0 → `error_flag`=1 after `perm_done`, no `dout_valid`, FSM back to IDLE.
  - Assert `reset_n` low during PERM_WAIT → IDLE, and a late `perm_done` is ignored.
